// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
// Pure declarations, no logic or latency.
// No flow control.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    WRITE_DONE = 2'd3
  } dmem_state_t;

  // Index bits needed to address every cache line.
  function automatic int dmem_idx_width(input int lines);
    return $clog2(lines);
  endfunction

  // Address bits above the index form the tag.
  function automatic int dmem_tag_width(input int lines, input int addr_width);
    return addr_width - $clog2(lines);
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Direct-mapped line store: valid, tag and data per line.
// Combinational read by index; the write port updates on the next rising edge.
// No backpressure; the valid bits clear asynchronously on reset.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAG_W = 26,
  parameter int IDX_W = dmem_idx_width(LINES)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic                       rd_valid,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [DMEM_DATA_WIDTH-1:0] rd_data,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic [DMEM_DATA_WIDTH-1:0] wr_data
);

  logic [LINES-1:0]           valid;
  logic [TAG_W-1:0]           tags  [LINES];
  logic [DMEM_DATA_WIDTH-1:0] datas [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = datas[rd_idx];

  // Valid bits: cleared by reset, set whenever a line is written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates their use.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      datas[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Write-through, no-allocate direct-mapped cache answering core en/we requests.
// Read hit: 0 cycles; read miss: backing latency + 1; write: backing latency + 1.
// stall holds the core while the backing handshake runs. Macro: DMEM_PERF_COUNTERS_EN.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       we,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DMEM_DATA_WIDTH-1:0] wd,
  output logic [DMEM_DATA_WIDTH-1:0] rd,
  output logic                       stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DMEM_DATA_WIDTH-1:0] mem_wd,
  input  logic                       mem_ack,
  input  logic [DMEM_DATA_WIDTH-1:0] mem_rd
`ifdef DMEM_PERF_COUNTERS_EN
  , output logic [31:0]              hit_count
  , output logic [31:0]              miss_count
`endif
);

  localparam int IDX_W = dmem_idx_width(LINES);
  localparam int TAG_W = dmem_tag_width(LINES, ADDR_WIDTH);

  dmem_state_t state, state_nxt;

  // While a backing transaction is open the lookup follows the captured
  // address, so the fill and write-hit update land on the right line even
  // if the core misbehaves and drops its request.
  logic [ADDR_WIDTH-1:0]      look_addr;
  logic [IDX_W-1:0]           look_idx;
  logic [TAG_W-1:0]           look_tag;
  logic                       line_valid;
  logic [TAG_W-1:0]           line_tag;
  logic [DMEM_DATA_WIDTH-1:0] line_data;
  logic                       hit;
  logic                       read_hit, read_miss, write_req;
  logic                       ack_rd, ack_wr;
  logic                       arr_wr_en;
  logic [DMEM_DATA_WIDTH-1:0] arr_wr_data;

  assign look_addr = (state == IDLE) ? addr : mem_addr;
  assign look_idx  = look_addr[IDX_W-1:0];
  assign look_tag  = look_addr[ADDR_WIDTH-1:IDX_W];
  assign hit       = line_valid && (line_tag == look_tag);

  assign read_hit  = (state == IDLE) && en && !we && hit;
  assign read_miss = (state == IDLE) && en && !we && !hit;
  assign write_req = (state == IDLE) && en && we;
  assign ack_rd    = (state == READ_WAIT) && mem_ack;
  assign ack_wr    = (state == WRITE_WAIT) && mem_ack;

  // Fills always allocate; writes only refresh a line that already holds the address.
  assign arr_wr_en   = ack_rd || (ack_wr && hit);
  assign arr_wr_data = ack_rd ? mem_rd : mem_wd;

  dmem_line_array #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_lines (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (look_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_wr_en),
    .wr_idx   (look_idx),
    .wr_tag   (look_tag),
    .wr_data  (arr_wr_data)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, stall and load data.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    rd        = '0;
    case (state)
      IDLE: begin
        if (read_hit) begin
          rd = line_data;
        end else if (read_miss) begin
          stall     = 1'b1;
          state_nxt = READ_WAIT;
        end else if (write_req) begin
          stall     = 1'b1;
          state_nxt = WRITE_WAIT;
        end
      end
      READ_WAIT: begin
        stall = 1'b1;
        if (mem_ack) state_nxt = IDLE;
      end
      WRITE_WAIT: begin
        stall = 1'b1;
        if (mem_ack) state_nxt = WRITE_DONE;
      end
      WRITE_DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Backing-memory request registers: launched from IDLE, dropped on ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else if (read_miss) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= addr;
    end else if (write_req) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b1;
      mem_addr <= addr;
      mem_wd   <= wd;
    end else if (ack_rd || ack_wr) begin
      mem_req  <= 1'b0;
    end
  end

`ifdef DMEM_PERF_COUNTERS_EN
  // Saturating hit/miss counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (read_hit && (hit_count != 32'hFFFF_FFFF))   hit_count  <= hit_count + 32'd1;
      if (read_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench with a load-data scoreboard and a bench-side backing memory.
// Latency of each backing response is chosen per step.
// All waits are bounded by a cycle budget.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        en, we;
  logic [31:0] addr, wd, rd;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic        mem_ack;
  logic [31:0] mem_rd;
`ifdef DMEM_PERF_COUNTERS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] bmem[logic [31:0]];

  always #5 clock = ~clock;

  data_memory_responder #(.LINES(64), .ADDR_WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_ack  (mem_ack),
    .mem_rd   (mem_rd)
`ifdef DMEM_PERF_COUNTERS_EN
    , .hit_count  (hit_count)
    , .miss_count (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bval(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // One core access: drives the request, plays the backing memory with the
  // given latency, and checks stall length, transaction count and load data.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input bit exp_mem);
    int cyc = 0, stall_cyc = 0, acks = 0, req_cyc = 0;
    bit done = 0;
    logic [31:0] got;
    en = 1'b1; we = w; addr = a; wd = d;
    if (!w) exp_q.push_back(bval(a));
    else    bmem[a] = d;
    while (!done && cyc < 50) begin
      @(negedge clock);
      cyc++;
      mem_ack = 1'b0;
      if (stall) begin
        stall_cyc++;
        if (mem_req) begin
          req_cyc++;
          if (req_cyc == lat) begin
            check({tag, ".mem_addr"}, mem_addr, a);
            check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, w});
            if (w) check({tag, ".mem_wd"}, mem_wd, d);
            mem_ack = 1'b1;
            mem_rd  = w ? 32'h0BAD_0BAD : bval(a);
            acks++;
            req_cyc = 0;
          end
        end
      end else begin
        done = 1;
        check({tag, ".req_after"}, {31'd0, mem_req}, 32'd0);
        if (!w) begin
          if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
          end else begin
            got = exp_q.pop_front();
            check({tag, ".rd"}, rd, got);
          end
        end
      end
    end
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".stall_cycles"}, stall_cyc, exp_mem ? lat + 1 : 0);
    check({tag, ".transactions"}, acks, exp_mem ? 1 : 0);
    @(posedge clock);
    #1;
    en = 1'b0; we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wd = '0;
    mem_ack = 1'b0; mem_rd = '0;
    bmem[32'h10] = 32'hDEAD_BEEF;
    #2;
    check("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check("rst.mem_we", {31'd0, mem_we}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wd", mem_wd, 32'd0);
    check("rst.stall", {31'd0, stall}, 32'd0);
    check("rst.rd", rd, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    access("rd10_miss", 1'b0, 32'h10, 32'h0, 3, 1'b1);
    access("rd10_hit", 1'b0, 32'h10, 32'h0, 1, 1'b0);
    access("wr10_hit", 1'b1, 32'h10, 32'h1234_5678, 2, 1'b1);
    access("rd10_after_wr", 1'b0, 32'h10, 32'h0, 1, 1'b0);

    // Idle cycle: no request means no stall and zero load data.
    @(negedge clock);
    check("idle.stall", {31'd0, stall}, 32'd0);
    check("idle.rd", rd, 32'd0);
    @(posedge clock);
    #1;

    access("wr20_miss", 1'b1, 32'h20, 32'hCAFE_F00D, 1, 1'b1);
    access("rd20_noalloc", 1'b0, 32'h20, 32'h0, 2, 1'b1);

    access("rd05_fill", 1'b0, 32'h05, 32'h0, 1, 1'b1);
    access("rd05_hit", 1'b0, 32'h05, 32'h0, 1, 1'b0);
    access("rd45_alias", 1'b0, 32'h45, 32'h0, 2, 1'b1);
    access("rd05_evicted", 1'b0, 32'h05, 32'h0, 1, 1'b1);

`ifdef DMEM_PERF_COUNTERS_EN
    check("perf.hit_count", hit_count, 32'd8);
    check("perf.miss_count", miss_count, 32'd5);
`endif

    // Reset in the middle of a read miss, then a stale ack after release.
    en = 1'b1; we = 1'b0; addr = 32'h30;
    @(negedge clock);
    @(negedge clock);
    check("abort.req_open", {31'd0, mem_req}, 32'd1);
    en = 1'b0;
    reset = 1'b1;
    #1;
    check("abort.mem_req", {31'd0, mem_req}, 32'd0);
    check("abort.stall", {31'd0, stall}, 32'd0);
    check("abort.rd", rd, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    mem_ack = 1'b1;
    mem_rd  = 32'hFFFF_0000;
    @(negedge clock);
    mem_ack = 1'b0;
    check("stale_ack.mem_req", {31'd0, mem_req}, 32'd0);
    check("stale_ack.stall", {31'd0, stall}, 32'd0);
    @(posedge clock);
    #1;
    access("rd10_after_reset", 1'b0, 32'h10, 32'h0, 1, 1'b1);

    check("sb.drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Slave end of the DataMemory interface. Answers the core's en/we/addr/wd requests with rd/stall.
- Sits between the core's EX/MEM stage and a slower backing memory.
- Contains a direct-mapped, one-word-per-line, write-through, write-no-allocate cache.
- Read hits complete in 0 clocks. Misses and all writes hold stall high while the backing handshake completes.

Parameters:
- LINES, 64: number of cache lines (power of two, ≥2); index = addr[$clog2(LINES)-1:0].
- ADDR_WIDTH, 32: width of the word address from the core; tag = addr[ADDR_WIDTH-1:$clog2(LINES)].

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  core request valid.
- we  in  1  1 = store, 0 = load.
- addr  in  ADDR_WIDTH  word address.
- wd  in  32  store data.
- rd  out  32  load data; valid when en & ~we & ~stall.
- stall  out  1  combinational; core holds en/we/addr/wd stable while high.
- mem_req  out  1  backing request, held until mem_ack.
- mem_we  out  1  backing store.
- mem_addr  out  ADDR_WIDTH  backing address.
- mem_wd  out  32  backing store data.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rd  in  32  backing load data, valid with mem_ack.

Behaviour:
- Reset (async):
  - state=IDLE, all valid bits=0, mem_req=0, mem_we=0, mem_addr=0, mem_wd=0.
  - Combinationally: stall=0, rd=0.
  - Data and tag arrays are not reset.
- States: IDLE, READ_WAIT, WRITE_WAIT, WRITE_DONE.
- hit = valid[idx] & (tag[idx]==addr tag); evaluated combinationally from the arrays.
- IDLE:
  - en=0: stall=0, rd=0.
  - en & ~we & hit: stall=0, rd=data[idx]; no state change.
  - en & ~we & ~hit: stall=1; next state READ_WAIT; register mem_req=1, mem_we=0, mem_addr=addr.
  - en & we: stall=1; next state WRITE_WAIT; register mem_req=1, mem_we=1, mem_addr=addr, mem_wd=wd.
- READ_WAIT:
  - stall=1.
  - On mem_ack: data[idx]=mem_rd, tag[idx]=addr tag, valid[idx]=1, mem_req=0, next IDLE.
  - The following cycle is a hit, so stall=0. Read-miss latency = backing latency + 1 cycle.
- WRITE_WAIT:
  - stall=1.
  - On mem_ack: mem_req=0, next WRITE_DONE.
  - If the line was a hit, data[idx]=wd.
  - On a miss, the cache is not allocated (no-allocate).
- WRITE_DONE:
  - stall=0 for exactly one cycle, which releases the core. Next state IDLE.
  - A request presented in this cycle is not re-served.
- mem_ack outside READ_WAIT/WRITE_WAIT is ignored. This includes a stale ack arriving after reset mid-transaction.
- mem_req stays high without timeout until mem_ack; stall stays high meanwhile.
- Reset asserted mid-transaction aborts it: mem_req drops immediately and the cache is invalidated.
- en falling during READ_WAIT/WRITE_WAIT is a protocol violation. The FSM still completes the backing transaction.
- Index wrap: addresses differing only in tag alias to the same line. A later read miss replaces the line.
- rd is 0 whenever the response is not a read hit in IDLE.

Optional Feature:
- DMEM_PERF_COUNTERS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per read hit served in IDLE; the post-fill hit counts as well.
  - miss_count increments once per READ_WAIT entry.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum (IDLE, READ_WAIT, WRITE_WAIT, WRITE_DONE).
  - functions for index/tag widths from LINES/ADDR_WIDTH.
  - DMEM_DATA_WIDTH=32.
- One sub-module: dmem_line_array.
  - Holds valid/tag/data.
  - Combinational read by index; synchronous write port; async valid clear on reset.

Test Plan:
- Reset, then read addr 0x10 with mem_ack after 3 cycles, mem_rd=0xDEADBEEF.
  -> stall high 4 cycles, then stall=0, rd=0xDEADBEEF, mem_req seen for exactly 1 transaction.
- Re-read 0x10 next cycle -> stall=0 same cycle, rd=0xDEADBEEF, no mem_req.
- Write 0x10 wd=0x12345678, ack after 2 cycles.
  -> mem_we=1, mem_wd=0x12345678, one WRITE_DONE cycle with stall=0; a following read of 0x10 hits with rd=0x12345678.
- Write 0x20 (miss).
  -> backing write issued; a subsequent read of 0x20 misses (no-allocate) and requests the backing memory.
- Alias test, LINES=64: fill 0x05, then read 0x45.
  -> miss and refill; a read of 0x05 misses again.
- Assert reset during READ_WAIT, then pulse mem_ack after reset release.
  -> mem_req=0 immediately, ack ignored, state IDLE, a previously cached address now misses.
